shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer for the bidirectional shift datapath. Takes one shift command
//  (direction + amount) through a start handshake, then drives a one-cycle
//  operand load followed by N shift cycles with mutually exclusive left/right
//  strobes, and ends with a done pulse. It sits between the top-level
//  control FSM and the shift-enable/direction decode of the shifter.
// PARAMETERS
//  CNT_W  4  width of shift amount and remaining-count register (max 2^CNT_W-1)
// PORTS
//  clk      in   1      single clock, all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      command request, sampled only in IDLE
//  dir      in   1      1 = shift left, 0 = shift right; captured with start
//  amt      in   CNT_W  number of shift cycles; captured with start
//  hold     in   1      stall: suppresses shift_en, freezes count (SHIFT only)
//  load_en  out  1      datapath operand load strobe
//  shift_en out  1      datapath shift strobe
//  left     out  1      shift_en & dir_q
//  right    out  1      shift_en & ~dir_q
//  busy     out  1      high in any state other than IDLE
//  done     out  1      one-cycle completion pulse
//  cnt      out  CNT_W  remaining shifts (registered)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, dir_q=0, cnt=0. All outputs are 0
//   in the following cycle. Reset overrides every other input, including
//   mid-command. An aborted command produces no done pulse.
//  States: IDLE, LOAD, SHIFT, DONE (2-bit register, one encoding per state).
//  IDLE:  start=1 -> LOAD, dir_q<=dir, cnt<=amt. Otherwise stay in IDLE.
//  LOAD:  load_en=1 for exactly one cycle. hold is ignored here.
//         If cnt==0 -> DONE, else -> SHIFT.
//  SHIFT: shift_en = ~hold (combinational path from hold).
//         On each cycle with shift_en=1, cnt<=cnt-1.
//         If shift_en=1 and cnt==1 -> DONE; otherwise stay in SHIFT.
//         With hold=1: state, cnt and dir_q are frozen.
//  DONE:  done=1 for one cycle, then -> IDLE unconditionally.
//  start is ignored outside IDLE, so back-to-back commands are spaced by at
//   least one IDLE cycle. Minimum start-to-start period is amt+3 cycles.
//  Latency (hold=0): start sampled at edge 0. LOAD in cycle 1. Shifts in
//   cycles 2..amt+1. done in cycle amt+2, or cycle 2 when amt==0.
//   Each hold cycle in SHIFT adds one cycle.
//  Invariants:
//   - left and right are never both 1.
//   - load_en, shift_en and done are mutually exclusive.
//   - shift_en is 0 outside SHIFT.
//   - cnt never wraps below 0. amt = 2^CNT_W-1 is legal (full range).
//  dir and amt are don't-care except in the cycle where start is accepted.
//   Changing them mid-command has no effect.
//  Illegal or unused state encodings -> IDLE on the next edge.
// TESTING
//  1 rst, then start=1 dir=1 amt=3 -> load_en cycle 1; shift_en=left=1 in
//    cycles 2-4 with cnt 3,2,1; done cycle 5; busy=0 cycle 6.
//  2 start dir=0 amt=0 -> load_en cycle 1, done cycle 2, shift_en/right
//    never asserted.
//  3 dir=0 amt=4, hold=1 in cycles 3-4 -> shift_en=right=1 in cycles 2,5,6,7;
//    cnt holds at 3 during hold; done cycle 8.
//  4 start re-pulsed and dir/amt toggled during busy -> ignored, original
//    command completes unchanged; new start accepted only from IDLE.
//  5 rst=1 during SHIFT with cnt=2 -> next cycle all outputs 0, busy=0,
//    cnt=0, no done pulse.
//  6 amt=15 (CNT_W=4) -> exactly 15 shift_en cycles, done cycle 17.
//    Assert left&right==0 and one-hot {load_en,shift_en,done} every cycle.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: accepts one {dir, amt} command from IDLE, issues a one-cycle
// operand load, amt shift strobes (stallable by hold), then a done pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; dir/amt captured on the accepting edge
// S_LOAD  | load_en asserted for one cycle; hold has no effect here
// S_SHIFT | shift_en = ~hold; count decrements on every unstalled cycle
// S_DONE  | done asserted for one cycle, then back to S_IDLE
module shift_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amt,
  input  logic             hold,
  output logic             load_en,
  output logic             shift_en,
  output logic             left,
  output logic             right,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             w_cnt_last;

  assign w_cnt_zero = (r_cnt == CNT_ZERO);
  assign w_cnt_last = (r_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_dir_nxt   = dir;
          w_cnt_nxt   = amt;
        end
      end
      S_LOAD: begin
        load_en     = 1'b1;
        w_state_nxt = w_cnt_zero ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = ~hold;
        if (!hold) begin
          // Zero guard keeps the count from wrapping if SHIFT is ever entered empty.
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
          if (w_cnt_last || w_cnt_zero) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign left  = shift_en & r_dir;
  assign right = shift_en & ~r_dir;
  assign busy  = (r_state != S_IDLE);
  assign cnt   = r_cnt;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector table, hand-written corner
// sequences and random traffic, all checked against a command-queue model.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, dir, hold;
  logic [3:0] amt;
  logic       load_en, shift_en, left, right, busy, done;
  logic [3:0] cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: each accepted command becomes a queue of steps L, S x amt, D.
  localparam byte ST_L = 1, ST_S = 2, ST_D = 3;
  byte  mq[$];
  logic m_dir = 1'b0;

  logic [9:0] obs;

  typedef struct {
    logic       r, s, d;
    logic [3:0] a;
    logic       h;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[$];

  shift_seq_ctrl #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .amt      (amt),
    .hold     (hold),
    .load_en  (load_en),
    .shift_en (shift_en),
    .left     (left),
    .right    (right),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(int r, int s, int d, int a, int h,
                              int ld, int sh, int l, int rt, int b, int dn, int c);
    vec_t v;
    v.r   = 1'(r);
    v.s   = 1'(s);
    v.d   = 1'(d);
    v.a   = 4'(a);
    v.h   = 1'(h);
    v.exp = {1'(ld), 1'(sh), 1'(l), 1'(rt), 1'(b), 1'(dn), 4'(c)};
    vecs.push_back(v);
  endfunction

  function automatic logic [9:0] model_out(logic h);
    logic [3:0] n_s;
    logic       is_l, is_s, is_d, sh;
    n_s = '0;
    foreach (mq[i]) if (mq[i] == ST_S) n_s = n_s + 4'd1;
    is_l = (mq.size() > 0) && (mq[0] == ST_L);
    is_s = (mq.size() > 0) && (mq[0] == ST_S);
    is_d = (mq.size() > 0) && (mq[0] == ST_D);
    sh   = is_s && !h;
    return {is_l, sh, sh & m_dir, sh & ~m_dir, (mq.size() > 0), is_d, n_s};
  endfunction

  // Called at posedge+1; applies inputs, samples at posedge+2, advances model.
  task automatic cycle(input logic r, input logic s, input logic d,
                       input logic [3:0] a, input logic h,
                       input bit vchk, input logic [9:0] vexp, input string nm);
    logic [9:0] mexp;
    rst = r; start = s; dir = d; amt = a; hold = h;
    #1;
    obs  = {load_en, shift_en, left, right, busy, done, cnt};
    mexp = model_out(h);
    checks++;
    if (obs !== mexp) begin
      errors++;
      $display("FAIL model[%s] cyc=%0d got=%b exp=%b (ld sh l r busy done cnt4)", nm, cyc, obs, mexp);
    end
    if (vchk) begin
      checks++;
      if (obs !== vexp) begin
        errors++;
        $display("FAIL vector[%s] cyc=%0d got=%b exp=%b", nm, cyc, obs, vexp);
      end
    end
    checks++;
    if (left && right) begin
      errors++;
      $display("FAIL left_right_excl cyc=%0d got=11 exp=not both", cyc);
    end
    checks++;
    if ($countones({load_en, shift_en, done}) > 1) begin
      errors++;
      $display("FAIL strobe_onehot cyc=%0d got=%b exp=at most one", cyc, {load_en, shift_en, done});
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_dir = 1'b0;
    end else if (mq.size() == 0) begin
      if (s) begin
        m_dir = d;
        mq.push_back(ST_L);
        for (int k = 0; k < int'(a); k++) mq.push_back(ST_S);
        mq.push_back(ST_D);
      end
    end else if (!(mq[0] == ST_S && h)) begin
      void'(mq.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic idle_cycle(input string nm);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 10'd0, nm);
  endtask

  initial begin
    int shifts;
    int done_at;

    rst = 1'b1; start = 1'b0; dir = 1'b0; amt = 4'd0; hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'd0, "reset_state");

    // dir=1 amt=3
    add(0,1,1,3,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,1,0,3);
    add(0,0,0,0,0, 0,1,1,0,1,0,3);
    add(0,0,0,0,0, 0,1,1,0,1,0,2);
    add(0,0,0,0,0, 0,1,1,0,1,0,1);
    add(0,0,0,0,0, 0,0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0);
    // dir=0 amt=0
    add(0,1,0,0,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0);
    // dir=0 amt=4 with hold in cycles 3-4
    add(0,1,0,4,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,1,0,4);
    add(0,0,0,0,0, 0,1,0,1,1,0,4);
    add(0,0,0,0,1, 0,0,0,0,1,0,3);
    add(0,0,0,0,1, 0,0,0,0,1,0,3);
    add(0,0,0,0,0, 0,1,0,1,1,0,3);
    add(0,0,0,0,0, 0,1,0,1,1,0,2);
    add(0,0,0,0,0, 0,1,0,1,1,0,1);
    add(0,0,0,0,0, 0,0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0);
    // start/dir/amt churn while busy, then a new command from IDLE
    add(0,1,1,2,0, 0,0,0,0,0,0,0);
    add(0,1,0,7,0, 1,0,0,0,1,0,2);
    add(0,1,0,7,0, 0,1,1,0,1,0,2);
    add(0,1,0,9,0, 0,1,1,0,1,0,1);
    add(0,1,0,1,0, 0,0,0,0,1,1,0);
    add(0,1,0,1,0, 0,0,0,0,0,0,0);
    add(0,0,1,5,0, 1,0,0,0,1,0,1);
    add(0,0,1,5,0, 0,1,0,1,1,0,1);
    add(0,0,0,0,0, 0,0,0,0,1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0);

    foreach (vecs[i])
      cycle(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].a, vecs[i].h, 1'b1, vecs[i].exp, "table");

    // Reset while shifting with cnt=2: no done afterwards
    cycle(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 10'b00_0000_0000, "rst_seq_start");
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'b10_0010_0100, "rst_seq_load");
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'b01_1010_0100, "rst_seq_sh4");
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'b01_1010_0011, "rst_seq_sh3");
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'b01_1010_0010, "rst_seq_sh2");
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 10'd0, "rst_seq_after");

    // Full-range amount
    cycle(1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 10'd0, "amt15_start");
    shifts  = 0;
    done_at = -1;
    for (int i = 1; i <= 24; i++) begin
      idle_cycle("amt15");
      if (obs[8]) shifts++;
      if (obs[4] && done_at < 0) done_at = i;
    end
    checks++;
    if (shifts != 15) begin
      errors++;
      $display("FAIL amt15_shift_count got=%0d exp=15", shifts);
    end
    checks++;
    if (done_at != 17) begin
      errors++;
      $display("FAIL amt15_done_cycle got=%0d exp=17", done_at);
    end

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(99) == 0),
            1'($urandom_range(2) == 0),
            1'($urandom_range(1)),
            4'($urandom_range(15)),
            1'($urandom_range(3) == 0),
            1'b0, 10'd0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
